// File: rtl/sector_buf_pkg.sv
// Shared definitions for the sector buffer arbiter: arbitration state
// encoding, requester identifiers and default RAM geometry.
package sector_buf_pkg;

  // Geometry of the single SB_RAM256x16 sector buffer.
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;

  // Width of the starvation counters; STARVE_LIMIT must fit (1..15).
  localparam int STARVE_W = 4;

  // Arbitration state. SWITCH is the one-cycle dead time used when BSY
  // ownership changes, so that no grant straddles a priority change.
  typedef enum logic [1:0] {
    HOST_PRI = 2'b00,
    MCU_PRI  = 2'b01,
    SWITCH   = 2'b10
  } arb_state_t;

  // Requester identifiers, used by the registered read-return tag.
  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_MCU  = 1'b1;

endpackage

// File: rtl/sector_buf_arbiter_if.sv
// One requester port onto the sector buffer.
//
// Handshake: the requester raises req with we/addr/wdata and holds all of
// them stable until gnt is seen high in the same cycle; the access happens
// in exactly the cycle where req && gnt. gnt is combinational. A granted
// read returns one cycle later as a single-cycle rvalid pulse carrying rdata;
// rdata keeps its last returned value while rvalid is low.
interface sector_buf_arbiter_if
  import sector_buf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  // Requester side (host taskfile logic, MCU SPI latch logic).
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/rr_starve_arb.sv
// Two-requester priority arbiter with a starvation bound. The priority
// requester wins contested cycles until the loser has lost STARVE_LIMIT
// times in a row; the loser then wins the next contested cycle.
// The pick outputs are tentative: the caller may veto a pick (hold), in
// which case the counter is left untouched for that cycle.
module rr_starve_arb
  import sector_buf_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                mcu_pri,
  input  logic                host_req,
  input  logic                mcu_req,
  input  logic                hold,
  output logic                host_pick,
  output logic                mcu_pick,
  output logic [STARVE_W-1:0] starve_cnt
);

  logic contested;
  logic limit_hit;

  assign contested = en && host_req && mcu_req;
  assign limit_hit = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

  // Pick a winner: priority side normally, the starved side once the
  // counter has reached the limit; uncontested requests always win.
  always_comb begin
    host_pick = 1'b0;
    mcu_pick  = 1'b0;
    if (contested) begin
      if (mcu_pri ^ limit_hit) begin
        mcu_pick = 1'b1;
      end else begin
        host_pick = 1'b1;
      end
    end else if (en) begin
      host_pick = host_req;
      mcu_pick  = mcu_req;
    end
  end

  // Count consecutive losses of the non-priority side; clear whenever the
  // loser is finally served or a grant goes through without contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (en && !hold) begin
      if (contested) begin
        starve_cnt <= limit_hit ? '0 : starve_cnt + STARVE_W'(1);
      end else if (host_req || mcu_req) begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sector_buf_arbiter.sv
// Shares the 256x16 sector buffer between the IDE host data path and the
// MCU SPI data path. Read and write RAM ports are arbitrated separately,
// priority follows BSY ownership (mcu_owns), and a same-address read/write
// collision defers the read so the write lands first.
module sector_buf_arbiter
  import sector_buf_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mcu_owns,
  sector_buf_arbiter_if.slave  host,
  sector_buf_arbiter_if.slave  mcu,
  output logic                 ram_re,
  output logic [ADDR_W-1:0]    ram_raddr,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_waddr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata,
  output logic [7:0]           conflict_cnt,
  output arb_state_t           state_dbg,
  output logic [STARVE_W-1:0]  read_starve_dbg,
  output logic [STARVE_W-1:0]  write_starve_dbg
);

  arb_state_t        state_q;
  logic              arb_en;
  logic              mcu_pri;

  logic              host_rd_req, mcu_rd_req;
  logic              host_wr_req, mcu_wr_req;
  logic              rd_host_pick, rd_mcu_pick;
  logic              wr_host_pick, wr_mcu_pick;
  logic              rd_any, wr_any;
  logic [ADDR_W-1:0] rd_addr_sel, wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;
  logic              hazard;
  logic              rd_gnt_host, rd_gnt_mcu;

  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              rvalid_q;
  logic              tag_q;
  logic              host_rv, mcu_rv;
  logic [DATA_W-1:0] host_rdata_q, mcu_rdata_q;

  // No grants at all during the SWITCH dead cycle.
  assign arb_en    = (state_q != SWITCH);
  assign mcu_pri   = (state_q == MCU_PRI);
  assign state_dbg = state_q;

  // Priority state machine: follow mcu_owns through one idle SWITCH cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= HOST_PRI;
    end else begin
      case (state_q)
        HOST_PRI: if (mcu_owns)  state_q <= SWITCH;
        MCU_PRI:  if (!mcu_owns) state_q <= SWITCH;
        SWITCH:   state_q <= mcu_owns ? MCU_PRI : HOST_PRI;
        default:  state_q <= HOST_PRI;
      endcase
    end
  end

  // A requester is either a reader or a writer in a given cycle.
  assign host_rd_req = host.req && !host.we;
  assign mcu_rd_req  = mcu.req  && !mcu.we;
  assign host_wr_req = host.req &&  host.we;
  assign mcu_wr_req  = mcu.req  &&  mcu.we;

  rr_starve_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_rd_arb (
    .clk        (clk),
    .reset      (reset),
    .en         (arb_en),
    .mcu_pri    (mcu_pri),
    .host_req   (host_rd_req),
    .mcu_req    (mcu_rd_req),
    .hold       (hazard),
    .host_pick  (rd_host_pick),
    .mcu_pick   (rd_mcu_pick),
    .starve_cnt (read_starve_dbg)
  );

  rr_starve_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
    .clk        (clk),
    .reset      (reset),
    .en         (arb_en),
    .mcu_pri    (mcu_pri),
    .host_req   (host_wr_req),
    .mcu_req    (mcu_wr_req),
    .hold       (1'b0),
    .host_pick  (wr_host_pick),
    .mcu_pick   (wr_mcu_pick),
    .starve_cnt (write_starve_dbg)
  );

  assign rd_any      = rd_host_pick || rd_mcu_pick;
  assign wr_any      = wr_host_pick || wr_mcu_pick;
  assign rd_addr_sel = rd_mcu_pick ? mcu.addr  : host.addr;
  assign wr_addr_sel = wr_mcu_pick ? mcu.addr  : host.addr;
  assign wr_data_sel = wr_mcu_pick ? mcu.wdata : host.wdata;

  // Same-address read and write in one cycle: the write goes, the read
  // waits a cycle so it observes the new data.
  assign hazard      = rd_any && wr_any && (rd_addr_sel == wr_addr_sel);
  assign rd_gnt_host = rd_host_pick && !hazard;
  assign rd_gnt_mcu  = rd_mcu_pick  && !hazard;

  assign host.gnt = rd_gnt_host || wr_host_pick;
  assign mcu.gnt  = rd_gnt_mcu  || wr_mcu_pick;

  // RAM ports: live values while granted, otherwise the last driven ones.
  assign ram_re    = rd_gnt_host || rd_gnt_mcu;
  assign ram_raddr = ram_re ? rd_addr_sel : raddr_q;
  assign ram_we    = wr_any;
  assign ram_waddr = ram_we ? wr_addr_sel : waddr_q;
  assign ram_wdata = ram_we ? wr_data_sel : wdata_q;

  // Remember the last driven RAM address/data so idle cycles hold them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      raddr_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (ram_re) raddr_q <= rd_addr_sel;
      if (ram_we) begin
        waddr_q <= wr_addr_sel;
        wdata_q <= wr_data_sel;
      end
    end
  end

  // Return tag: which requester owns the RAM read data next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      tag_q    <= REQ_HOST;
    end else begin
      rvalid_q <= ram_re;
      if (ram_re) tag_q <= rd_gnt_mcu ? REQ_MCU : REQ_HOST;
    end
  end

  assign host_rv     = rvalid_q && (tag_q == REQ_HOST);
  assign mcu_rv      = rvalid_q && (tag_q == REQ_MCU);
  assign host.rvalid = host_rv;
  assign mcu.rvalid  = mcu_rv;
  assign host.rdata  = host_rv ? ram_rdata : host_rdata_q;
  assign mcu.rdata   = mcu_rv  ? ram_rdata : mcu_rdata_q;

  // Keep each requester's last returned word visible between returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      host_rdata_q <= '0;
      mcu_rdata_q  <= '0;
    end else begin
      if (host_rv) host_rdata_q <= ram_rdata;
      if (mcu_rv)  mcu_rdata_q  <= ram_rdata;
    end
  end

  // Saturating count of reads deferred by a same-address write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt <= '0;
    end else if (hazard && (conflict_cnt != 8'hFF)) begin
      conflict_cnt <= conflict_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_sector_buf_arbiter.sv
// Directed bench for sector_buf_arbiter with a behavioural SB_RAM256x16
// model and per-requester expected read-return queues.
module tb_sector_buf_arbiter;
  import sector_buf_pkg::*;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          mcu_owns;
  logic          ram_re, ram_we;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic [7:0]    conflict_cnt;
  arb_state_t    state_dbg;
  logic [3:0]    read_starve_dbg, write_starve_dbg;

  sector_buf_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) host_if ();
  sector_buf_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mcu_if ();

  sector_buf_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .mcu_owns         (mcu_owns),
    .host             (host_if.slave),
    .mcu              (mcu_if.slave),
    .ram_re           (ram_re),
    .ram_raddr        (ram_raddr),
    .ram_we           (ram_we),
    .ram_waddr        (ram_waddr),
    .ram_wdata        (ram_wdata),
    .ram_rdata        (ram_rdata),
    .conflict_cnt     (conflict_cnt),
    .state_dbg        (state_dbg),
    .read_starve_dbg  (read_starve_dbg),
    .write_starve_dbg (write_starve_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- RAM model (registered read) ----------------
  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_host_q[$];
  logic [DW-1:0] exp_mcu_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Read-return monitor: every rvalid must match the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (host_if.rvalid) begin
        if (exp_host_q.size() == 0) check("host_rvalid_unexpected", 32'(host_if.rvalid), 32'd0);
        else check("host_rdata", 32'(host_if.rdata), 32'(exp_host_q.pop_front()));
      end
      if (mcu_if.rvalid) begin
        if (exp_mcu_q.size() == 0) check("mcu_rvalid_unexpected", 32'(mcu_if.rvalid), 32'd0);
        else check("mcu_rdata", 32'(mcu_if.rdata), 32'(exp_mcu_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic host_drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_if.req = req; host_if.we = we; host_if.addr = a; host_if.wdata = d;
  endtask

  task automatic mcu_drive(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mcu_if.req = req; mcu_if.we = we; mcu_if.addr = a; mcu_if.wdata = d;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_host_gnt"},    32'(host_if.gnt),    32'd0);
    check({pfx, "_mcu_gnt"},     32'(mcu_if.gnt),     32'd0);
    check({pfx, "_host_rvalid"}, 32'(host_if.rvalid), 32'd0);
    check({pfx, "_mcu_rvalid"},  32'(mcu_if.rvalid),  32'd0);
    check({pfx, "_host_rdata"},  32'(host_if.rdata),  32'd0);
    check({pfx, "_mcu_rdata"},   32'(mcu_if.rdata),   32'd0);
    check({pfx, "_ram_re"},      32'(ram_re),         32'd0);
    check({pfx, "_ram_we"},      32'(ram_we),         32'd0);
    check({pfx, "_ram_raddr"},   32'(ram_raddr),      32'd0);
    check({pfx, "_ram_waddr"},   32'(ram_waddr),      32'd0);
    check({pfx, "_ram_wdata"},   32'(ram_wdata),      32'd0);
    check({pfx, "_conflict"},    32'(conflict_cnt),   32'd0);
    check({pfx, "_state"},       32'(state_dbg),      32'(HOST_PRI));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic host_wins;

    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 257 + 7);
      ref_mem[i] = 16'(i * 257 + 7);
    end
    mem[8'h10] = 16'hBEEF; ref_mem[8'h10] = 16'hBEEF;

    reset = 1'b0; mcu_owns = 1'b0;
    host_drive(0, 0, 0, 0);
    mcu_drive(0, 0, 0, 0);
    repeat (3) tick();
    mid();
    check_reset_outputs("rst");
    tick();
    reset = 1'b1;
    tick();

    // Host-only read of 0x10 returns 0xBEEF one cycle later.
    host_drive(1, 0, 8'h10, 0);
    exp_host_q.push_back(ref_mem[8'h10]);
    mid();
    check("rd1_host_gnt", 32'(host_if.gnt), 32'd1);
    check("rd1_mcu_gnt",  32'(mcu_if.gnt),  32'd0);
    check("rd1_ram_re",   32'(ram_re),      32'd1);
    check("rd1_raddr",    32'(ram_raddr),   32'h10);
    tick();
    host_drive(0, 0, 0, 0);
    mid();
    check("rd1_host_rvalid", 32'(host_if.rvalid), 32'd1);
    check("rd1_mcu_rvalid",  32'(mcu_if.rvalid),  32'd0);
    check("rd1_idle_re",     32'(ram_re),         32'd0);
    check("rd1_raddr_hold",  32'(ram_raddr),      32'h10);
    tick();

    // Hand priority to the MCU through one SWITCH cycle.
    mcu_owns = 1'b1;
    mid(); check("sw1_state_a", 32'(state_dbg), 32'(HOST_PRI));
    tick();
    mid(); check("sw1_state_b", 32'(state_dbg), 32'(SWITCH));
    tick();
    mid(); check("sw1_state_c", 32'(state_dbg), 32'(MCU_PRI));
    tick();

    // Contested reads under MCU priority: four MCU grants, then one host.
    host_drive(1, 0, 8'h10, 0);
    mcu_drive(1, 0, 8'h11, 0);
    for (int i = 0; i < 10; i++) begin
      host_wins = ((i % 5) == 4);
      if (host_wins) exp_host_q.push_back(ref_mem[8'h10]);
      else exp_mcu_q.push_back(ref_mem[8'h11]);
      mid();
      check("starve_rd_host_gnt", 32'(host_if.gnt), 32'(host_wins));
      check("starve_rd_mcu_gnt",  32'(mcu_if.gnt),  32'(!host_wins));
      check("starve_rd_raddr",    32'(ram_raddr),   host_wins ? 32'h10 : 32'h11);
      tick();
    end
    host_drive(0, 0, 0, 0);
    mcu_drive(0, 0, 0, 0);
    tick();

    // Same-address hazard: host write 0x1234 @0x20 vs mcu read @0x20.
    host_drive(1, 1, 8'h20, 16'h1234);
    mcu_drive(1, 0, 8'h20, 0);
    ref_mem[8'h20] = 16'h1234;
    mid();
    check("haz_host_gnt", 32'(host_if.gnt), 32'd1);
    check("haz_mcu_gnt",  32'(mcu_if.gnt),  32'd0);
    check("haz_ram_we",   32'(ram_we),      32'd1);
    check("haz_ram_re",   32'(ram_re),      32'd0);
    check("haz_waddr",    32'(ram_waddr),   32'h20);
    check("haz_wdata",    32'(ram_wdata),   32'h1234);
    tick();
    host_drive(0, 0, 0, 0);
    exp_mcu_q.push_back(ref_mem[8'h20]);
    mid();
    check("haz_conflict", 32'(conflict_cnt), 32'd1);
    check("haz_retry_gnt", 32'(mcu_if.gnt),  32'd1);
    check("haz_retry_raddr", 32'(ram_raddr), 32'h20);
    tick();
    mcu_drive(0, 0, 0, 0);
    tick();

    // Independent read and write in one cycle, then read back the write.
    host_drive(1, 0, 8'h05, 0);
    mcu_drive(1, 1, 8'h06, 16'hA5A5);
    exp_host_q.push_back(ref_mem[8'h05]);
    ref_mem[8'h06] = 16'hA5A5;
    mid();
    check("ind_host_gnt", 32'(host_if.gnt), 32'd1);
    check("ind_mcu_gnt",  32'(mcu_if.gnt),  32'd1);
    check("ind_ram_re",   32'(ram_re),      32'd1);
    check("ind_ram_we",   32'(ram_we),      32'd1);
    check("ind_raddr",    32'(ram_raddr),   32'h05);
    check("ind_waddr",    32'(ram_waddr),   32'h06);
    check("ind_conflict", 32'(conflict_cnt), 32'd1);
    tick();
    mcu_drive(0, 0, 0, 0);
    host_drive(1, 0, 8'h06, 0);
    exp_host_q.push_back(ref_mem[8'h06]);
    mid();
    check("rb_host_gnt", 32'(host_if.gnt), 32'd1);
    tick();
    host_drive(0, 0, 0, 0);
    tick();

    // Contested writes under MCU priority follow the same starvation rule.
    for (int i = 0; i < 5; i++) begin
      host_drive(1, 1, 8'h30, 16'(16'h1000 + i));
      mcu_drive(1, 1, 8'h31, 16'(16'h2000 + i));
      host_wins = (i == 4);
      mid();
      check("starve_wr_host_gnt", 32'(host_if.gnt), 32'(host_wins));
      check("starve_wr_mcu_gnt",  32'(mcu_if.gnt),  32'(!host_wins));
      check("starve_wr_wdata",    32'(ram_wdata),
            host_wins ? 32'(16'h1000 + i) : 32'(16'h2000 + i));
      tick();
    end
    host_drive(0, 0, 0, 0);
    mcu_drive(0, 0, 0, 0);

    // Back to host priority.
    mcu_owns = 1'b0;
    tick();
    tick();
    mid(); check("sw2_state", 32'(state_dbg), 32'(HOST_PRI));
    tick();

    // Toggle ownership during continuous host reads: one dead cycle only.
    host_drive(1, 0, 8'h10, 0);
    exp_host_q.push_back(ref_mem[8'h10]);
    mid();
    check("tog_a_gnt",   32'(host_if.gnt), 32'd1);
    check("tog_a_state", 32'(state_dbg),   32'(HOST_PRI));
    tick();
    mcu_owns = 1'b1;
    exp_host_q.push_back(ref_mem[8'h10]);
    mid();
    check("tog_b_gnt",   32'(host_if.gnt), 32'd1);
    check("tog_b_state", 32'(state_dbg),   32'(HOST_PRI));
    tick();
    mid();
    check("tog_c_gnt",    32'(host_if.gnt), 32'd0);
    check("tog_c_ram_re", 32'(ram_re),      32'd0);
    check("tog_c_state",  32'(state_dbg),   32'(SWITCH));
    tick();
    exp_host_q.push_back(ref_mem[8'h10]);
    mid();
    check("tog_d_gnt",   32'(host_if.gnt), 32'd1);
    check("tog_d_state", 32'(state_dbg),   32'(MCU_PRI));
    tick();
    host_drive(0, 0, 0, 0);
    tick();

    // Reset in the cycle after a granted read: the return is dropped.
    host_drive(1, 0, 8'h05, 0);
    mid();
    check("rstrd_gnt", 32'(host_if.gnt), 32'd1);
    tick();
    reset = 1'b0;
    mcu_owns = 1'b0;
    host_drive(0, 0, 0, 0);
    mid();
    check_reset_outputs("rstrd");
    tick();
    reset = 1'b1;
    mid();
    check("rstrd_rel_rvalid", 32'(host_if.rvalid), 32'd0);
    check("rstrd_rel_state",  32'(state_dbg),      32'(HOST_PRI));
    repeat (3) tick();

    check("host_q_empty", 32'(exp_host_q.size()), 32'd0);
    check("mcu_q_empty",  32'(exp_mcu_q.size()),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
